rv32i_mtimer: RTL and testbench

Machine-timer responder for the rv32i SoC. It holds the RISC-V `mtime` and `mtimecmp` registers and the software-interrupt bit `msip`, and generates the core's timer and software interrupt requests. It accepts the SoC-level direct 64-bit load ports (`mtime_wr`/`mtimecmp_wr`) and also answers word accesses on a simple 32-bit memory-mapped bus. It sits beside the core, and its interrupt outputs feed the CSR unit's pending bits.

---
 rtl/rv32i_mtimer_pkg.sv | 27 ++
 rtl/rv32i_tick_gen.sv | 36 +++
 rtl/rv32i_mtimer.sv | 119 +++++++++++
 tb/tb_rv32i_mtimer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_mtimer_pkg.sv
// Word map, reset constants and half-word merge helper shared by the machine-timer block.
// Combinational only; no latency or backpressure of its own.
package rv32i_mtimer_pkg;

    localparam logic [2:0] MTIME_LO    = 3'd0;
    localparam logic [2:0] MTIME_HI    = 3'd1;
    localparam logic [2:0] MTIMECMP_LO = 3'd2;
    localparam logic [2:0] MTIMECMP_HI = 3'd3;
    localparam logic [2:0] MSIP        = 3'd4;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace one 32-bit half of a 64-bit register, keeping the other half.
    function automatic logic [63:0] merge_half(input logic [63:0] cur,
                                               input logic        hi,
                                               input logic [31:0] wd);
        logic [63:0] res;
        res = cur;
        if (hi) begin
            res[63:32] = wd;
        end else begin
            res[31:0] = wd;
        end
        return res;
    endfunction

endpackage

// File: rtl/rv32i_tick_gen.sv
// Prescaler: one-cycle tick every CLK_FREQ_MHZ cycles; tick is combinational from the count register.
// No backpressure; i_clear restarts the period from zero on the next edge.
module rv32i_tick_gen #(
    parameter int CLK_FREQ_MHZ = 100
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [15:0] LAST = 16'(CLK_FREQ_MHZ - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        tick;

    assign tick   = (cnt_q == LAST);
    assign o_tick = tick;

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (i_clear || tick) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rv32i_mtimer.sv
// RISC-V mtime/mtimecmp/msip with direct 64-bit loads and a 32-bit word bus; ack and read data 1 cycle after i_stb.
// Never stalls: every strobe is acknowledged, back-to-back strobes give back-to-back acks.
module rv32i_mtimer
    import rv32i_mtimer_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mtime_wr,
    input  logic [63:0] i_mtime_din,
    input  logic        i_mtimecmp_wr,
    input  logic [63:0] i_mtimecmp_din,
    input  logic        i_stb,
    input  logic        i_wr_en,
    input  logic [2:0]  i_addr,
    input  logic [31:0] i_wr_data,
    output logic        o_ack,
    output logic [31:0] o_rd_data,
    output logic [63:0] o_mtime,
    output logic        o_timer_interrupt,
    output logic        o_software_interrupt
);

    logic [63:0] mtime_q,    mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q,     msip_d;
    logic        tint_q,     tint_d;
    logic        ack_q,      ack_d;
    logic [31:0] rd_data_q,  rd_data_d;

    logic        tick;
    logic        presc_clear;
    logic        bus_wr;
    logic [31:0] rd_sel;

    assign bus_wr = i_stb & i_wr_en;

    rv32i_tick_gen #(
        .CLK_FREQ_MHZ(CLK_FREQ_MHZ)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clear(presc_clear),
        .o_tick (tick)
    );

    // Any write to mtime restarts the microsecond period and swallows a coincident tick.
    always_comb begin
        mtime_d     = mtime_q;
        presc_clear = 1'b0;
        if (i_mtime_wr) begin
            mtime_d     = i_mtime_din;
            presc_clear = 1'b1;
        end else if (bus_wr && (i_addr == MTIME_LO || i_addr == MTIME_HI)) begin
            mtime_d     = merge_half(mtime_q, i_addr[0], i_wr_data);
            presc_clear = 1'b1;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (i_mtimecmp_wr) begin
            mtimecmp_d = i_mtimecmp_din;
        end else if (bus_wr && (i_addr == MTIMECMP_LO || i_addr == MTIMECMP_HI)) begin
            mtimecmp_d = merge_half(mtimecmp_q, i_addr[0], i_wr_data);
        end
    end

    always_comb begin
        msip_d = msip_q;
        if (bus_wr && i_addr == MSIP) begin
            msip_d = i_wr_data[0];
        end
    end

    always_comb begin
        rd_sel = 32'd0;
        case (i_addr)
            MTIME_LO:    rd_sel = mtime_q[31:0];
            MTIME_HI:    rd_sel = mtime_q[63:32];
            MTIMECMP_LO: rd_sel = mtimecmp_q[31:0];
            MTIMECMP_HI: rd_sel = mtimecmp_q[63:32];
            MSIP:        rd_sel = {31'd0, msip_q};
            default:     rd_sel = 32'd0;
        endcase
    end

    assign ack_d     = i_stb;
    assign rd_data_d = (i_stb && !i_wr_en) ? rd_sel : 32'd0;
    assign tint_d    = (mtime_q >= mtimecmp_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RESET;
            msip_q     <= 1'b0;
            tint_q     <= 1'b0;
            ack_q      <= 1'b0;
            rd_data_q  <= 32'd0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            tint_q     <= tint_d;
            ack_q      <= ack_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign o_mtime              = mtime_q;
    assign o_timer_interrupt    = tint_q;
    assign o_software_interrupt = msip_q;
    assign o_ack                = ack_q;
    assign o_rd_data            = rd_data_q;

endmodule

// File: tb/tb_rv32i_mtimer.sv
// Bench for rv32i_mtimer: directed sequences, a bus vector table, and a random run against a cycle model.
module tb_rv32i_mtimer;

    localparam int F = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mtime_wr = 1'b0;
    logic [63:0] mtime_din = '0;
    logic        cmp_wr = 1'b0;
    logic [63:0] cmp_din = '0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] wd = '0;
    logic        ack;
    logic [31:0] rd_data;
    logic [63:0] mtime;
    logic        tint;
    logic        swi;

    int n_tests = 0;
    int n_fail  = 0;

    rv32i_mtimer #(.CLK_FREQ_MHZ(F)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_mtime_wr          (mtime_wr),
        .i_mtime_din         (mtime_din),
        .i_mtimecmp_wr       (cmp_wr),
        .i_mtimecmp_din      (cmp_din),
        .i_stb               (stb),
        .i_wr_en             (we),
        .i_addr              (addr),
        .i_wr_data           (wd),
        .o_ack               (ack),
        .o_rd_data           (rd_data),
        .o_mtime             (mtime),
        .o_timer_interrupt   (tint),
        .o_software_interrupt(swi)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference model: architectural state plus cycles elapsed since the prescaler last restarted.
    logic [63:0] m_mt, m_cmp;
    logic        m_msip, m_tint, m_ack;
    logic [31:0] m_rd;
    int          m_since;

    task automatic m_reset();
        m_mt = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_msip = 1'b0;
        m_tint = 1'b0; m_ack = 1'b0; m_rd = 32'd0; m_since = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_mt[31:0];
            3'd1:    return m_mt[63:32];
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return {31'd0, m_msip};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model from the inputs now driven, then compare 1 time unit after the edge.
    task automatic step();
        logic [63:0] n_mt, n_cmp;
        logic        n_msip, bw, clr, t;
        t      = ((m_since % F) == F - 1);
        bw     = stb && we;
        n_mt   = m_mt;
        n_cmp  = m_cmp;
        n_msip = m_msip;
        clr    = 1'b0;
        if (mtime_wr) begin
            n_mt = mtime_din; clr = 1'b1;
        end else if (bw && addr == 3'd0) begin
            n_mt[31:0] = wd; clr = 1'b1;
        end else if (bw && addr == 3'd1) begin
            n_mt[63:32] = wd; clr = 1'b1;
        end else if (t) begin
            n_mt = m_mt + 64'd1;
        end
        if (cmp_wr) n_cmp = cmp_din;
        else if (bw && addr == 3'd2) n_cmp[31:0] = wd;
        else if (bw && addr == 3'd3) n_cmp[63:32] = wd;
        if (bw && addr == 3'd4) n_msip = wd[0];
        m_tint  = (m_mt >= m_cmp);
        m_ack   = stb;
        m_rd    = (stb && !we) ? m_read(addr) : 32'd0;
        m_mt    = n_mt;
        m_cmp   = n_cmp;
        m_msip  = n_msip;
        m_since = clr ? 0 : m_since + 1;
        @(posedge clk);
        #1;
        chk("model_mtime", mtime, m_mt);
        chk("model_tint", {63'd0, tint}, {63'd0, m_tint});
        chk("model_swi", {63'd0, swi}, {63'd0, m_msip});
        chk("model_ack", {63'd0, ack}, {63'd0, m_ack});
        chk("model_rd", {32'd0, rd_data}, {32'd0, m_rd});
    endtask

    task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d);
        stb = 1'b1; we = w; addr = a; wd = d;
        step();
        stb = 1'b0; we = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [31:0] lo;
        bit          hit;
        m_reset();

        tbl[0]  = '{1'b1, 3'd2, 32'h1234_5678, 32'd0};
        tbl[1]  = '{1'b1, 3'd3, 32'h9ABC_DEF0, 32'd0};
        tbl[2]  = '{1'b0, 3'd2, 32'd0,         32'h1234_5678};
        tbl[3]  = '{1'b0, 3'd3, 32'd0,         32'h9ABC_DEF0};
        tbl[4]  = '{1'b1, 3'd4, 32'hFFFF_FFFE, 32'd0};
        tbl[5]  = '{1'b0, 3'd4, 32'd0,         32'd0};
        tbl[6]  = '{1'b1, 3'd4, 32'd3,         32'd0};
        tbl[7]  = '{1'b0, 3'd4, 32'd0,         32'd1};
        tbl[8]  = '{1'b1, 3'd6, 32'hDEAD_BEEF, 32'd0};
        tbl[9]  = '{1'b0, 3'd6, 32'd0,         32'd0};
        tbl[10] = '{1'b1, 3'd3, 32'd0,         32'd0};
        tbl[11] = '{1'b0, 3'd3, 32'd0,         32'd0};

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_mtime", mtime, 64'd0);
        chk("rst_tint", {63'd0, tint}, 64'd0);
        chk("rst_swi", {63'd0, swi}, 64'd0);
        chk("rst_ack", {63'd0, ack}, 64'd0);
        chk("rst_rd", {32'd0, rd_data}, 64'd0);
        rst = 1'b0;

        // Free-running time base
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i <= 3) chk("t1_mtime_early", mtime, 64'd0);
            if (i == 4) chk("t1_first_tick", mtime, 64'd1);
        end
        chk("t1_mtime_40", mtime, 64'd10);
        chk("t1_tint_40", {63'd0, tint}, 64'd0);

        // Timer interrupt raised by a direct mtimecmp load
        cmp_wr = 1'b1; cmp_din = 64'd15;
        step();
        cmp_wr = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            step();
            hit = (mtime == 64'd15);
        end
        chk("t2_reach15", mtime, 64'd15);
        chk("t2_tint_lag", {63'd0, tint}, 64'd0);
        step();
        chk("t2_tint_rise", {63'd0, tint}, 64'd1);
        hit = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            hit = hit && tint;
        end
        chk("t2_tint_hold", {63'd0, hit}, 64'd1);

        // Bus write upper half, read both halves back
        lo = mtime[31:0];
        bus(1'b1, 3'd1, 32'h0000_0001);
        chk("t3_wr_ack", {63'd0, ack}, 64'd1);
        chk("t3_mtime", mtime, {32'd1, lo});
        bus(1'b0, 3'd0, 32'd0);
        chk("t3_rd0_ack", {63'd0, ack}, 64'd1);
        chk("t3_rd0", {32'd0, rd_data}, {32'd0, lo});
        bus(1'b0, 3'd1, 32'd0);
        chk("t3_rd1_ack", {63'd0, ack}, 64'd1);
        chk("t3_rd1", {32'd0, rd_data}, 64'd1);
        step();
        chk("t3_ack_drop", {63'd0, ack}, 64'd0);
        chk("t3_rd_idle", {32'd0, rd_data}, 64'd0);

        // Wrap of mtime at 2^64
        mtime_wr = 1'b1; mtime_din = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        mtime_wr = 1'b0;
        chk("t4_loaded", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        step(); step(); step();
        chk("t4_pre_wrap", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("t4_wrap", mtime, 64'd0);
        chk("t4_tint_still", {63'd0, tint}, 64'd1);
        step();
        chk("t4_tint_fall", {63'd0, tint}, 64'd0);

        // Direct load beats a same-cycle bus write
        cmp_wr = 1'b1; cmp_din = 64'd100;
        bus(1'b1, 3'd2, 32'd5);
        cmp_wr = 1'b0;
        chk("t5_ack", {63'd0, ack}, 64'd1);
        bus(1'b0, 3'd2, 32'd0);
        chk("t5_cmp_lo", {32'd0, rd_data}, 64'd100);
        bus(1'b0, 3'd3, 32'd0);
        chk("t5_cmp_hi", {32'd0, rd_data}, 64'd0);
        bus(1'b0, 3'd7, 32'd0);
        chk("t5_unmapped_ack", {63'd0, ack}, 64'd1);
        chk("t5_unmapped", {32'd0, rd_data}, 64'd0);

        // Back-to-back bus vectors
        for (int i = 0; i < 12; i++) begin
            stb = 1'b1; we = tbl[i].w; addr = tbl[i].a; wd = tbl[i].d;
            step();
            chk($sformatf("vec%0d_ack", i), {63'd0, ack}, 64'd1);
            chk($sformatf("vec%0d_rd", i), {32'd0, rd_data}, {32'd0, tbl[i].exp_rd});
        end
        stb = 1'b0; we = 1'b0;
        step();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            stb  = ($urandom_range(0, 2) == 0);
            we   = $urandom_range(0, 1);
            addr = 3'($urandom_range(0, 7));
            wd   = (addr == 3'd1 || addr == 3'd3) ? 32'($urandom_range(0, 1)) : $urandom;
            mtime_wr  = ($urandom_range(0, 15) == 0);
            mtime_din = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15))
                                                    : m_mt + 64'($urandom_range(0, 20));
            cmp_wr  = ($urandom_range(0, 11) == 0);
            cmp_din = m_mt + 64'($urandom_range(0, 12));
            step();
        end
        stb = 1'b0; we = 1'b0; mtime_wr = 1'b0; cmp_wr = 1'b0;
        step();

        // Software interrupt, then reset with an ack outstanding
        bus(1'b1, 3'd4, 32'hFFFF_FFFF);
        chk("t6_swi", {63'd0, swi}, 64'd1);
        cmp_wr = 1'b1; cmp_din = 64'd0;
        bus(1'b0, 3'd2, 32'd0);
        cmp_wr = 1'b0;
        step(); step();
        stb = 1'b1; we = 1'b0; addr = 3'd0;
        step();
        stb = 1'b0;
        chk("t6_pre_ack", {63'd0, ack}, 64'd1);
        chk("t6_pre_tint", {63'd0, tint}, 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_mtime", mtime, 64'd0);
        chk("t6_rst_tint", {63'd0, tint}, 64'd0);
        chk("t6_rst_swi", {63'd0, swi}, 64'd0);
        chk("t6_rst_ack", {63'd0, ack}, 64'd0);
        chk("t6_rst_rd", {32'd0, rd_data}, 64'd0);
        m_reset();
        #1 rst = 1'b0;
        bus(1'b0, 3'd2, 32'd0);
        chk("t6_cmp_lo", {32'd0, rd_data}, 64'hFFFF_FFFF);
        bus(1'b0, 3'd3, 32'd0);
        chk("t6_cmp_hi", {32'd0, rd_data}, 64'hFFFF_FFFF);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
